// File: rtl/oifs_tx_fifo.sv
// oifs_tx_fifo: FIFO-buffered FTDI fast opto-isolated serial transmitter (FSCLK/FSDI/FSCTS).
// Define OIFS_TX_FRAME_CNT_EN to add the 16-bit o_frame_cnt completed-frame counter.
module oifs_tx_fifo #(
  parameter int CLK_DIV = 2,
  parameter int FIFO_AW = 4,
  parameter int GAP_CYC = 4
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [7:0]         i_data,
  input  logic               i_chan,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [FIFO_AW:0]   o_level,
  input  logic               i_fscts,
  output logic               o_fsclk,
  output logic               o_fsdi,
  output logic               o_busy,
  output logic               o_tick
`ifdef OIFS_TX_FRAME_CNT_EN
  ,output logic [15:0]       o_frame_cnt
`endif
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYC) + 1;
  localparam int LW = FIFO_AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT_CTS, SHIFT, GAP} state_t;
  state_t               r_state, w_next;
  logic [8:0]           r_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0]   r_wptr, r_rptr;
  logic [FIFO_AW:0]     r_level;
  logic [1:0]           r_cts_s;
  logic [9:0]           r_shreg;
  logic [3:0]           r_bit;
  logic [DW-1:0]        r_div;
  logic [GW-1:0]        r_gap;
  logic                 r_fsclk, r_tick;
  logic                 w_push, w_pop, w_div_wrap, w_last, w_gap_done;
  assign w_push     = i_valid && o_ready;
  assign w_pop      = (r_state == WAIT_CTS) && r_cts_s[1];
  assign w_div_wrap = r_div == DW'(CLK_DIV - 1);
  assign w_last     = (r_state == SHIFT) && w_div_wrap && r_fsclk && (r_bit == 4'd9);
  assign w_gap_done = r_gap == GW'(GAP_CYC - 1);
  assign o_ready    = ~r_level[FIFO_AW];
  assign o_level    = r_level;
  assign o_fsclk    = r_fsclk;
  assign o_fsdi     = (r_state == SHIFT) ? r_shreg[0] : 1'b1;
  assign o_busy     = r_state != IDLE;
  assign o_tick     = r_tick;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= {i_chan, i_data};
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cts_s <= '0;
    end else begin
      r_cts_s <= {r_cts_s[0], i_fscts};
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (r_level != '0) ? WAIT_CTS : IDLE;
      WAIT_CTS: w_next = r_cts_s[1] ? SHIFT : WAIT_CTS;
      SHIFT:    w_next = w_last ? GAP : SHIFT;
      default:  w_next = w_gap_done ? IDLE : GAP;
    endcase
  end
  // FSDI advances on the FSCLK falling edge so it is stable across the FTDI's rising-edge sample
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_shreg <= '1;
      r_bit   <= '0;
      r_div   <= '0;
      r_fsclk <= 1'b0;
      r_gap   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_last;
      r_gap  <= (r_state == GAP) ? r_gap + GW'(1) : '0;
      if (w_pop) begin
        r_shreg <= {r_mem[r_rptr], 1'b0};
        r_bit   <= '0;
        r_div   <= '0;
        r_fsclk <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_div <= w_div_wrap ? '0 : r_div + DW'(1);
        if (w_div_wrap) r_fsclk <= ~r_fsclk;
        if (w_div_wrap && r_fsclk) begin
          r_shreg <= {1'b1, r_shreg[9:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end
    end
`ifdef OIFS_TX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) r_frame_cnt <= '0;
    else if (r_tick) r_frame_cnt <= r_frame_cnt + 16'd1;
  assign o_frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_oifs_tx_fifo.sv
// tb_oifs_tx_fifo: directed bench with a frame/occupancy scoreboard checked every cycle
// plus literal expectations for latency, bit patterns, backpressure and async reset.
module tb_oifs_tx_fifo;
  localparam int CLK_DIV = 2;
  localparam int FIFO_AW = 2;
  localparam int GAP_CYC = 4;
  localparam int DEPTH   = 4;
  logic             i_clk = 1'b0;
  logic             i_arst_n;
  logic [7:0]       i_data;
  logic             i_chan, i_valid, i_fscts;
  logic             o_ready, o_fsclk, o_fsdi, o_busy, o_tick;
  logic [FIFO_AW:0] o_level;
`ifdef OIFS_TX_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif
  oifs_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .GAP_CYC(GAP_CYC)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_data(i_data), .i_chan(i_chan), .i_valid(i_valid),
    .o_ready(o_ready), .o_level(o_level), .i_fscts(i_fscts), .o_fsclk(o_fsclk), .o_fsdi(o_fsdi),
    .o_busy(o_busy), .o_tick(o_tick)
`ifdef OIFS_TX_FRAME_CNT_EN
    , .o_frame_cnt(frame_cnt)
`endif
  );
  always #5 i_clk = ~i_clk;
  int vec = 0, miscomp = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Scoreboard: expected frames {chan,data,start}, modelled occupancy, observed serial stream
  logic [9:0] q[$];
  logic [9:0] rx, last_rx, exp_frame;
  int  mlevel = 0, cyc = 0, start_cyc = 0, tick_cyc = 0, nbit = 0, rises = 0, ticks = 0;
  bit  pend = 0, in_frame = 0, have_tick = 0, started, prev_fsclk = 0, prev_fsdi = 1;
  always @(negedge i_clk) begin
    if (!i_arst_n) begin
      q.delete();
      mlevel = 0; pend = 0; in_frame = 0; nbit = 0; have_tick = 0;
      prev_fsclk = 0; prev_fsdi = 1;
    end else begin
      cyc++;
      started = !in_frame && prev_fsdi && !o_fsdi;
      if (started) begin
        if (have_tick) chk("gap_len", (cyc - tick_cyc) >= GAP_CYC, 1);
        in_frame = 1; nbit = 0; start_cyc = cyc;
      end
      mlevel = mlevel + int'(pend) - int'(started);
      pend = 0;
      chk("level", o_level, mlevel);
      chk("ready", o_ready, mlevel < DEPTH);
      if (!o_busy) chk("idle_pins", {o_fsclk, o_fsdi}, 2'b01);
      if (o_fsdi != prev_fsdi) chk("fsdi_change_fsclk_low", o_fsclk, 0);
      if (o_fsclk && !prev_fsclk) begin
        rises++;
        if (nbit < 10) rx[nbit] = o_fsdi;
        nbit++;
      end
      if (o_tick) begin
        ticks++;
        chk("bits_per_frame", nbit, 10);
        chk("shift_len", cyc - start_cyc, 20 * CLK_DIV);
        chk("frame_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_frame = q.pop_front();
          chk("frame", rx, exp_frame);
        end
        last_rx = rx; in_frame = 0; tick_cyc = cyc; have_tick = 1;
      end
      if (i_valid && mlevel < DEPTH) begin
        pend = 1;
        q.push_back({i_chan, i_data, 1'b0});
      end
      prev_fsclk = o_fsclk; prev_fsdi = o_fsdi;
    end
  end
  task automatic step();
    @(negedge i_clk); #1;
  endtask
  task automatic push(input logic [7:0] d, input logic c);
    @(posedge i_clk); #1;
    i_data = d; i_chan = c; i_valid = 1;
    @(posedge i_clk); #1;
    i_valid = 0;
  endtask
  task automatic wait_ticks(input int target, input int budget);
    int c = 0;
    while (ticks < target && c < budget) begin step(); c++; end
    chk("tick_wait", ticks >= target, 1);
  endtask
  task automatic wait_nbit(input int n);
    int c = 0;
    while (!(in_frame && nbit >= n) && c < 200) begin step(); c++; end
    chk("nbit_wait", in_frame && nbit >= n, 1);
  endtask
  task automatic wait_idle();
    int c = 0;
    while (o_busy && c < 200) begin step(); c++; end
    chk("idle_wait", o_busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  int t0, r0;
  initial begin
    i_arst_n = 0; i_valid = 0; i_data = '0; i_chan = 0; i_fscts = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_fsclk", o_fsclk, 0);
    chk("rst_fsdi", o_fsdi, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_tick", o_tick, 0);
    chk("rst_level", o_level, 0);
    chk("rst_ready", o_ready, 1);
    i_arst_n = 1; i_fscts = 1;
    repeat (3) step();
    // Single byte: latency N+3 and the 10-bit A5 pattern
    t0 = ticks;
    push(8'hA5, 0);
    step();
    chk("lat_n1_fsdi", o_fsdi, 1);
    chk("lat_n1_level", o_level, 1);
    step();
    chk("lat_n2_fsdi", o_fsdi, 1);
    step();
    chk("lat_n3_fsdi", o_fsdi, 0);
    chk("lat_n3_level", o_level, 0);
    wait_ticks(t0 + 1, 200);
    chk("a5_bits", last_rx, 10'h14A);
    wait_idle();
    chk("a5_one_tick", ticks - t0, 1);
    // Backpressure with FSCTS low, then drain
    i_fscts = 0;
    repeat (4) step();
    r0 = rises;
    @(posedge i_clk); #1;
    i_valid = 1;
    for (int i = 0; i < 5; i++) begin
      i_data = 8'h10 + 8'(i); i_chan = i[0];
      @(posedge i_clk); #1;
    end
    i_valid = 0;
    step();
    chk("full_ready", o_ready, 0);
    chk("full_level", o_level, 4);
    repeat (10) step();
    chk("no_fsclk_cts_low", rises, r0);
    chk("wait_cts_busy", o_busy, 1);
    t0 = ticks;
    i_fscts = 1;
    wait_ticks(t0 + 4, 600);
    wait_idle();
    chk("four_frames", ticks - t0, 4);
    chk("fourth_frame_bits", last_rx, 10'h226);
    // FSCTS drop mid-frame: current frame completes, next waits
    t0 = ticks;
    push(8'h3C, 0);
    push(8'hC3, 1);
    wait_nbit(4);
    i_fscts = 0;
    wait_ticks(t0 + 1, 200);
    chk("drop_frame_bits", last_rx, 10'h078);
    r0 = rises;
    repeat (30) step();
    chk("held_busy", o_busy, 1);
    chk("held_level", o_level, 1);
    chk("held_ticks", ticks - t0, 1);
    chk("held_no_fsclk", rises, r0);
    i_fscts = 1;
    wait_ticks(t0 + 2, 200);
    chk("resumed_frame_bits", last_rx, 10'h386);
    wait_idle();
    // Simultaneous push and pop at level 2
    i_fscts = 0;
    repeat (4) step();
    t0 = ticks;
    push(8'h01, 1);
    push(8'h02, 0);
    repeat (3) step();
    chk("pre_simul_level", o_level, 2);
    @(posedge i_clk); #1;
    i_fscts = 1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_data = 8'h03; i_chan = 1; i_valid = 1;
    @(posedge i_clk); #1;
    i_valid = 0;
    step();
    chk("simul_level", o_level, 2);
    wait_ticks(t0 + 3, 400);
    chk("third_frame_bits", last_rx, 10'h206);
    wait_idle();
    // Async reset at bit 6
    push(8'hFF, 0);
    push(8'h55, 1);
    wait_nbit(6);
    chk("pre_rst_fsclk", o_fsclk, 1);
    #2 i_arst_n = 0;
    #1;
    chk("arst_fsclk", o_fsclk, 0);
    chk("arst_fsdi", o_fsdi, 1);
    chk("arst_level", o_level, 0);
    chk("arst_busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    #1 i_arst_n = 1;
    r0 = rises; t0 = ticks;
    repeat (20) step();
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_level", o_level, 0);
    chk("post_rst_no_fsclk", rises, r0);
    chk("post_rst_no_tick", ticks, t0);
    push(8'h96, 0);
    wait_ticks(t0 + 1, 200);
    chk("post_rst_frame_bits", last_rx, 10'h12C);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end
endmodule
